echo_delay_line: RTL and testbench

Multi-tap echo generator for one MIDI voice channel. It captures every change of the channel's note state into a timestamped circular event queue. Each event is replayed after a programmable delay with attenuated velocity, and is fed back for a programmable number of repeats. It sits between the per-channel MIDI decoder outputs and the echo voice allocator, and generalises the fixed 16-slot, fixed-delay, single-repeat echo block.

---
 rtl/echo_delay_line.sv | 138 +++++++++++++
 tb/tb_echo_delay_line.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_line.sv
// Multi-tap echo generator for one MIDI voice channel.
// Timestamped note-state changes are replayed after a delay, then re-queued with decayed velocity.
module echo_delay_line #(
  parameter int DEPTH = 16,
  parameter int TW    = 24,
  parameter int RW    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     tick,
  input  logic [TW-2:0]            delay,
  input  logic [1:0]               decay_shift,
  input  logic [RW-1:0]            repeats,
  input  logic                     note_on,
  input  logic [6:0]               note_start,
  input  logic [6:0]               vel_start,
  input  logic [8:0]               pb_start,
  input  logic [1:0]               cc1_start,
  output logic                     echo_valid,
  output logic                     echo_on,
  output logic [6:0]               echo_note,
  output logic [6:0]               echo_vel,
  output logic [8:0]               echo_pb,
  output logic [1:0]               echo_cc1,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] ONE_W   = (AW+2)'(1);

  logic          q_on   [DEPTH];
  logic [6:0]    q_note [DEPTH];
  logic [6:0]    q_vel  [DEPTH];
  logic [8:0]    q_pb   [DEPTH];
  logic [1:0]    q_cc1  [DEPTH];
  logic [TW-1:0] q_due  [DEPTH];
  logic [RW-1:0] q_rem  [DEPTH];

  logic [AW-1:0] head, tail;
  logic [TW-1:0] now;
  logic          sh_on;
  logic [6:0]    sh_note, sh_vel;
  logic [8:0]    sh_pb;
  logic [1:0]    sh_cc1;

  logic [TW-1:0] delay_eff, due_new, age;
  logic [2:0]    shift;
  logic          pop, capture, requeue, cap_ok, req_ok;
  logic [AW+1:0] free;
  logic [AW-1:0] req_idx;

  // Keeping the delay below a quarter of the timer range makes the age MSB a wrap-safe "due" test.
  always_comb begin
    delay_eff = {2'b00, delay[TW-3:0]};
    due_new   = now + delay_eff;
    shift     = {1'b0, decay_shift} + 3'd1;
    age       = now - q_due[head];
    pop       = (count != '0) && !age[TW-1];
    capture   = ({note_on, note_start, vel_start, pb_start, cc1_start} !=
                 {sh_on, sh_note, sh_vel, sh_pb, sh_cc1}) && (repeats != '0);
    requeue   = pop && (q_rem[head] > RW'(1));
    free      = DEPTH_W - {1'b0, count} + {{(AW+1){1'b0}}, pop};
    cap_ok    = capture && (free != '0);
    req_ok    = requeue && (cap_ok ? (free > ONE_W) : (free != '0));
    req_idx   = cap_ok ? tail + AW'(1) : tail;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      now        <= '0;
      sh_on      <= 1'b0;
      sh_note    <= '0;
      sh_vel     <= '0;
      sh_pb      <= '0;
      sh_cc1     <= '0;
      overflow   <= 1'b0;
      echo_valid <= 1'b0;
      echo_on    <= 1'b0;
      echo_note  <= '0;
      echo_vel   <= '0;
      echo_pb    <= '0;
      echo_cc1   <= '0;
    end else if (en) begin
      now        <= now + TW'(tick);
      sh_on      <= note_on;
      sh_note    <= note_start;
      sh_vel     <= vel_start;
      sh_pb      <= pb_start;
      sh_cc1     <= cc1_start;
      echo_valid <= pop;
      if (pop) begin
        echo_on   <= q_on[head];
        echo_note <= q_note[head];
        echo_vel  <= q_vel[head];
        echo_pb   <= q_pb[head];
        echo_cc1  <= q_cc1[head];
      end
      head  <= head + AW'(pop);
      tail  <= tail + AW'(cap_ok) + AW'(req_ok);
      count <= count + (AW+1)'(cap_ok) + (AW+1)'(req_ok) - (AW+1)'(pop);
      if ((capture && !cap_ok) || (requeue && !req_ok))
        overflow <= 1'b1;
    end else begin
      echo_valid <= 1'b0;
    end
  end

  // Queue storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && en) begin
      if (cap_ok) begin
        q_on[tail]   <= note_on;
        q_note[tail] <= note_start;
        q_vel[tail]  <= vel_start >> shift;
        q_pb[tail]   <= pb_start;
        q_cc1[tail]  <= cc1_start;
        q_due[tail]  <= due_new;
        q_rem[tail]  <= repeats;
      end
      if (req_ok) begin
        q_on[req_idx]   <= q_on[head];
        q_note[req_idx] <= q_note[head];
        q_vel[req_idx]  <= q_vel[head] >> shift;
        q_pb[req_idx]   <= q_pb[head];
        q_cc1[req_idx]  <= q_cc1[head];
        q_due[req_idx]  <= due_new;
        q_rem[req_idx]  <= q_rem[head] - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_line.sv
// Bench for echo_delay_line: a queue-based event model checked every cycle,
// plus directed scenarios with hand-computed timing and field values.
module tb_echo_delay_line;

  localparam int DEPTH = 4;
  localparam int TW    = 8;
  localparam int RW    = 3;

  logic       clk, reset, en, tick;
  logic [6:0] delay;
  logic [1:0] decay_shift;
  logic [2:0] repeats;
  logic       note_on;
  logic [6:0] note_start, vel_start;
  logic [8:0] pb_start;
  logic [1:0] cc1_start;
  logic       echo_valid, echo_on, overflow;
  logic [6:0] echo_note, echo_vel;
  logic [8:0] echo_pb;
  logic [1:0] echo_cc1;
  logic [2:0] count;

  echo_delay_line #(.DEPTH(DEPTH), .TW(TW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .en(en), .tick(tick), .delay(delay),
    .decay_shift(decay_shift), .repeats(repeats), .note_on(note_on),
    .note_start(note_start), .vel_start(vel_start), .pb_start(pb_start),
    .cc1_start(cc1_start), .echo_valid(echo_valid), .echo_on(echo_on),
    .echo_note(echo_note), .echo_vel(echo_vel), .echo_pb(echo_pb),
    .echo_cc1(echo_cc1), .overflow(overflow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending events, timestamps kept modulo 2^TW.
  typedef struct {
    bit       on;
    bit [6:0] note;
    bit [6:0] vel;
    bit [8:0] pb;
    bit [1:0] cc1;
    int       due;
    int       rem;
  } ev_t;

  ev_t      mq[$];
  ev_t      m_head, m_new;
  int       mnow, m_free, m_shift, m_dly;
  bit       m_pop, m_cap, m_ovf;
  bit       s_on;
  bit [6:0] s_note, s_vel;
  bit [8:0] s_pb;
  bit [1:0] s_cc1;
  bit       x_valid, x_on;
  bit [6:0] x_note, x_vel;
  bit [8:0] x_pb;
  bit [1:0] x_cc1;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mnow = 0; m_ovf = 0;
      s_on = 0; s_note = 0; s_vel = 0; s_pb = 0; s_cc1 = 0;
      x_valid = 0; x_on = 0; x_note = 0; x_vel = 0; x_pb = 0; x_cc1 = 0;
    end else if (en) begin
      m_shift = int'(decay_shift) + 1;
      m_dly   = int'(delay) % (1 << (TW - 2));
      m_pop   = (mq.size() != 0) && (((mnow - mq[0].due) & 255) < 128);
      x_valid = m_pop;
      if (m_pop) begin
        m_head = mq.pop_front();
        x_on = m_head.on; x_note = m_head.note; x_vel = m_head.vel;
        x_pb = m_head.pb; x_cc1 = m_head.cc1;
      end
      m_cap = ({note_on, note_start, vel_start, pb_start, cc1_start} !=
               {s_on, s_note, s_vel, s_pb, s_cc1}) && (repeats != 0);
      s_on = note_on; s_note = note_start; s_vel = vel_start;
      s_pb = pb_start; s_cc1 = cc1_start;
      m_free = DEPTH - mq.size();
      if (m_cap) begin
        if (m_free > 0) begin
          m_new.on = note_on; m_new.note = note_start; m_new.vel = vel_start >> m_shift;
          m_new.pb = pb_start; m_new.cc1 = cc1_start;
          m_new.due = (mnow + m_dly) % 256; m_new.rem = int'(repeats);
          mq.push_back(m_new);
          m_free--;
        end else m_ovf = 1;
      end
      if (m_pop && m_head.rem > 1) begin
        if (m_free > 0) begin
          m_new = m_head;
          m_new.vel = m_head.vel >> m_shift;
          m_new.due = (mnow + m_dly) % 256;
          m_new.rem = m_head.rem - 1;
          mq.push_back(m_new);
        end else m_ovf = 1;
      end
      mnow = (mnow + int'(tick)) % 256;
    end else begin
      x_valid = 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("echo_valid", int'(echo_valid), int'(x_valid));
      checkOutput("echo_on", int'(echo_on), int'(x_on));
      checkOutput("echo_note", int'(echo_note), int'(x_note));
      checkOutput("echo_vel", int'(echo_vel), int'(x_vel));
      checkOutput("echo_pb", int'(echo_pb), int'(x_pb));
      checkOutput("echo_cc1", int'(echo_cc1), int'(x_cc1));
      checkOutput("count", int'(count), mq.size());
      checkOutput("overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic applyStimulus(input bit on, input int note, input int vel,
                               input int pb, input int cc1);
    @(posedge clk); #1;
    note_on    = on;
    note_start = 7'(note);
    vel_start  = 7'(vel);
    pb_start   = 9'(pb);
    cc1_start  = 2'(cc1);
  endtask

  task automatic waitEcho(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!echo_valid && n < 600);
    if (!echo_valid) checkOutput("echo_timeout", 0, 1);
  endtask

  int n, extra, guard;
  int exp_vel[3] = '{25, 6, 1};

  initial begin
    reset = 1; en = 1; tick = 1; delay = 0; decay_shift = 0; repeats = 0;
    note_on = 0; note_start = 0; vel_start = 0; pb_start = 0; cc1_start = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_en = 1;
    @(negedge clk);
    checkOutput("rst_valid", int'(echo_valid), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_vel", int'(echo_vel), 0);

    // Basic single echo: delay 10, velocity halved
    repeats = 1; delay = 10; decay_shift = 0;
    applyStimulus(1, 60, 100, 'h155, 2);
    waitEcho(n);
    checkOutput("basic_latency", n, 12);
    checkOutput("basic_on", int'(echo_on), 1);
    checkOutput("basic_note", int'(echo_note), 60);
    checkOutput("basic_vel", int'(echo_vel), 50);
    checkOutput("basic_pb", int'(echo_pb), 'h155);
    checkOutput("basic_cc1", int'(echo_cc1), 2);
    checkOutput("basic_count", int'(count), 0);

    // Change while repeats=0 is tracked but not captured
    repeats = 0;
    applyStimulus(0, 60, 100, 'h155, 2);
    repeat (2) @(negedge clk);
    checkOutput("disabled_count", int'(count), 0);

    // Three repeats with shift 2: 100 -> 25, 6, 1, then matching gate-offs
    repeats = 3; decay_shift = 1; delay = 5;
    applyStimulus(1, 64, 100, 'h0A0, 1);
    for (int i = 0; i < 3; i++) begin
      waitEcho(n);
      checkOutput("multi_on_vel", int'(echo_vel), exp_vel[i]);
      checkOutput("multi_on_gate", int'(echo_on), 1);
    end
    applyStimulus(0, 64, 100, 'h0A0, 1);
    for (int i = 0; i < 3; i++) begin
      waitEcho(n);
      checkOutput("multi_off_vel", int'(echo_vel), exp_vel[i]);
      checkOutput("multi_off_gate", int'(echo_on), 0);
    end

    // Overflow: six captures into a 4-entry queue
    repeats = 1; delay = 60; decay_shift = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1, 10 + i, 100, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("ovf_count", int'(count), 4);
    checkOutput("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      waitEcho(n);
      checkOutput("ovf_order", int'(echo_note), 10 + i);
    end
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (echo_valid) extra++;
    end
    checkOutput("ovf_no_extra", extra, 0);

    // Capture lands on the emission cycle of an rem=2 entry
    repeats = 2; delay = 8;
    applyStimulus(1, 20, 100, 'h1FF, 3);
    repeat (8) @(posedge clk);
    #1 note_start = 21;
    @(negedge clk);
    @(negedge clk);
    checkOutput("simul_valid", int'(echo_valid), 1);
    checkOutput("simul_note", int'(echo_note), 20);
    checkOutput("simul_count", int'(count), 2);
    waitEcho(n);
    checkOutput("simul_first", int'(echo_note), 21);
    waitEcho(n);
    checkOutput("simul_second", int'(echo_note), 20);
    checkOutput("simul_second_vel", int'(echo_vel), 25);
    waitEcho(n);
    checkOutput("simul_third", int'(echo_note), 21);
    repeat (20) @(negedge clk);

    // Timer wrap: capture at now=250 with delay 20 is due at now=14
    repeats = 1; delay = 20;
    guard = 0;
    while (mnow != 250 && guard < 600) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("wrap_reach_250", mnow, 250);
    note_start = 30;
    waitEcho(n);
    checkOutput("wrap_latency", n, 22);
    checkOutput("wrap_note", int'(echo_note), 30);

    // Enable dropped for 50 cycles mid-delay
    delay = 30;
    applyStimulus(1, 40, 100, 0, 0);
    repeat (10) @(posedge clk);
    #1 en = 0;
    repeat (50) @(posedge clk);
    #1 en = 1;
    waitEcho(n);
    checkOutput("en_latency", n, 22);
    checkOutput("en_note", int'(echo_note), 40);

    // Reset with three echoes pending
    delay = 40;
    for (int i = 0; i < 3; i++) applyStimulus(1, 50 + i, 100, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_count", int'(count), 3);
    @(posedge clk); #1;
    reset = 1;
    note_on = 0; note_start = 0; vel_start = 0; pb_start = 0; cc1_start = 0;
    @(posedge clk); #1;
    reset = 0;
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (echo_valid) extra++;
    end
    checkOutput("reset_no_echo", extra, 0);
    checkOutput("reset_note", int'(echo_note), 0);
    checkOutput("reset_vel", int'(echo_vel), 0);
    checkOutput("reset_on", int'(echo_on), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_count", int'(count), 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
